axi_stream_dw_upsizer_pipe: RTL and testbench
=============================================

AXI_STREAM_DW_UPSIZER_PIPE -- requirements
Module: axi_stream_dw_upsizer_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DataWidthIn, 8, input tdata width in bits.
- DataWidthOut, 64, output tdata width in bits.
- IdWidth, 0, tid width.
- DestWidth, 0, tdest width.
- UserWidth, 0, tuser width.
- OutDepth, 2, output buffer depth in words (>=1).
- FlushOnIdChange, 1, if set, a tid/tdest change closes the partial word.
- axi_stream_in_req_t / axi_stream_in_rsp_t / axi_stream_out_req_t / axi_stream_out_rsp_t, logic, port struct types.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk_i, in, 1, clock; all logic on its rising edge.
- rst_i, in, 1, reset, asynchronous, active-high.
- in_req_i, in, struct, input tvalid plus t.{data,strb,keep,last,id,dest,user}.
- in_rsp_o, out, struct, input tready.
- out_req_o, out, struct, output tvalid plus t.*.
- out_rsp_i, in, struct, output tready.

Function
REQ-003 The ratio R SHALL equal DataWidthOut/DataWidthIn; R SHALL be an integer >=2, and DataWidthIn SHALL be a multiple of 8 (elaboration assertion).
REQ-004 A lane counter of width max(1,$clog2(R)) SHALL place accepted beat k at data[k*DataWidthIn +: DataWidthIn], with strb and keep at the matching byte lanes; the first beat SHALL land in the lowest lane.
REQ-005 A word SHALL close when any of these holds: the lane counter reaches R-1; the accepted beat has last=1; or FlushOnIdChange=1, counter>0 and the beat's id/dest differ from the held id/dest.
REQ-006 On close, unfilled lanes SHALL carry data, strb and keep of 0; the word SHALL be pushed to the output buffer in the same cycle, with no pad cycles.
REQ-007 On an id/dest-change close, the partial word SHALL be pushed with last=0, and the triggering beat SHALL start the next word in lane 0 in the same cycle.
REQ-008 The pushed word SHALL carry id, dest and user of its final beat, and last of its final beat.
REQ-009 in_rsp_o.tready SHALL be 1 when the presented beat needs no push or the output buffer is not full; otherwise 0.
- tready may depend combinationally on tvalid and beat content.
REQ-010 The output buffer SHALL be a registered FIFO of OutDepth words.
- out_req_o.tvalid = not empty.
- A pop is out tvalid & tready.
- A push and a pop in the same cycle on a non-full buffer SHALL both occur.
REQ-011 Latency from the closing beat's acceptance to out tvalid SHALL be 1 cycle (buffer empty).
REQ-012 With out tready held 1, sustained throughput SHALL be 1 input beat per cycle with no bubbles across word boundaries.
REQ-013 On close, the counter SHALL wrap to 0, or to 1 per REQ-007.
REQ-014 While the input is stalled (tvalid=1, tready=0), the assembly register and counter SHALL hold.
REQ-015 Output payload SHALL remain stable while out tvalid=1 and tready=0.

Reset
REQ-016 While rst_i=1, the module SHALL hold: counter 0; assembly data/strb/keep/id/dest/user/last 0; buffer empty; out_req_o.tvalid 0; out_req_o.t 0.
REQ-017 Reset mid-packet SHALL discard partial and buffered words with no residual output after release.
REQ-018 The first cycle after release SHALL accept input normally.

Structure
REQ-019 A shared package axi_stream_dw_pkg SHALL hold a ratio/counter-width helper function, reused by the downsizer.
REQ-020 The output buffer SHALL be a single sub-module instance of stream_fifo (common_cells) parametrised with OutDepth and the output payload type.
- Assembly and flush logic stays in this module.

Verification (DataWidthIn=8, DataWidthOut=32, OutDepth=2)
REQ-021 Input 0x11,0x22,0x33,0x44 (keep=1, last on 4th), out tready=1 -> one word data 0x44332211, keep 0xF, last=1, valid the cycle after beat 4.
REQ-022 Input 0xAA,0xBB with last on 2nd -> data 0x0000BBAA, keep 0x3, strb 0x3, last=1; next packet starts in lane 0.
REQ-023 id=1 beats 0x01,0x02 then id=2 beat 0x03 (last), FlushOnIdChange=1 -> words 0x00000201 (keep 0x3, id 1, last 0) then 0x00000003 (keep 0x1, id 2, last 1).
REQ-024 Continuous 16 beats, out tready=1 -> 4 words, in tready never 0.
REQ-025 Out tready=0 with buffer full -> in tready=0 only on the closing beat; payload stable; release -> no loss or duplication.
REQ-026 rst_i pulse after 2 of 4 beats -> out tvalid 0, counter 0; a fresh 4-beat packet yields exactly one correct word.

Source files
------------

// File: rtl/axi_stream_dw_pkg.sv
// Shared helpers and default port types for the AXI-Stream data-width converters.
package axi_stream_dw_pkg;

  function automatic int unsigned dw_ratio(input int unsigned wide_w, input int unsigned narrow_w);
    return wide_w / narrow_w;
  endfunction

  function automatic int unsigned dw_cnt_width(input int unsigned ratio);
    return (ratio > 2) ? $clog2(ratio) : 1;
  endfunction

  // Defaults describe an 8 -> 64 bit converter with 1-bit sideband placeholders.
  typedef struct packed {
    logic [7:0] data;
    logic [0:0] strb;
    logic [0:0] keep;
    logic       last;
    logic [0:0] id;
    logic [0:0] dest;
    logic [0:0] user;
  } dflt_in_t;

  typedef struct packed {
    logic     tvalid;
    dflt_in_t t;
  } dflt_in_req_t;

  typedef struct packed {
    logic tready;
  } dflt_rsp_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic        last;
    logic [0:0]  id;
    logic [0:0]  dest;
    logic [0:0]  user;
  } dflt_out_t;

  typedef struct packed {
    logic      tvalid;
    dflt_out_t t;
  } dflt_out_req_t;

endpackage

// File: rtl/axi_stream_dw_upsizer_pipe_fifo.sv
// Registered FIFO with valid/ready on both sides; push and pop may coincide when not full.
module stream_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  T     data_i,
  input  logic valid_i,
  output logic ready_o,
  output T     data_o,
  output logic valid_o,
  input  logic ready_i
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          push, pop;

  assign ready_o = (cnt_q != (AW+1)'(DEPTH));
  assign valid_o = (cnt_q != '0);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;
  assign data_o  = mem_q[rd_q];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= nxt(wr_q);
      end
      if (pop) rd_q <= nxt(rd_q);
      if (push != pop) cnt_q <= push ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/axi_stream_dw_upsizer_pipe.sv
// AXI-Stream width upsizer: packs R narrow beats into one wide word, closing early on
// last or on an id/dest change, and queues finished words in a small output FIFO.
module axi_stream_dw_upsizer_pipe
  import axi_stream_dw_pkg::*;
#(
  parameter int unsigned DataWidthIn     = 8,
  parameter int unsigned DataWidthOut    = 64,
  parameter int unsigned IdWidth         = 0,
  parameter int unsigned DestWidth       = 0,
  parameter int unsigned UserWidth       = 0,
  parameter int unsigned OutDepth        = 2,
  parameter bit          FlushOnIdChange = 1'b1,
  parameter type axi_stream_in_req_t     = dflt_in_req_t,
  parameter type axi_stream_in_rsp_t     = dflt_rsp_t,
  parameter type axi_stream_out_req_t    = dflt_out_req_t,
  parameter type axi_stream_out_rsp_t    = dflt_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  axi_stream_in_req_t  in_req_i,
  output axi_stream_in_rsp_t  in_rsp_o,
  output axi_stream_out_req_t out_req_o,
  input  axi_stream_out_rsp_t out_rsp_i
);
  localparam int unsigned R   = dw_ratio(DataWidthOut, DataWidthIn);
  localparam int unsigned CW  = dw_cnt_width(R);
  localparam int unsigned SI  = DataWidthIn / 8;
  localparam int unsigned SO  = DataWidthOut / 8;
  localparam int unsigned IW  = (IdWidth > 0) ? IdWidth : 1;
  localparam int unsigned DsW = (DestWidth > 0) ? DestWidth : 1;
  localparam int unsigned UW  = (UserWidth > 0) ? UserWidth : 1;

  if ((DataWidthIn % 8) != 0 || (DataWidthOut % DataWidthIn) != 0 || R < 2) begin : g_bad_cfg
    $error("axi_stream_dw_upsizer_pipe: unsupported data width configuration");
  end

  typedef struct packed {
    logic [DataWidthOut-1:0] data;
    logic [SO-1:0]           strb;
    logic [SO-1:0]           keep;
    logic                    last;
    logic [IW-1:0]           id;
    logic [DsW-1:0]          dest;
    logic [UW-1:0]           user;
  } word_t;

  word_t         asm_q, asm_d, beat_w, merged, push_word, fifo_q;
  logic [CW-1:0] cnt_q, cnt_d, lane;
  logic          pend_q, pend_d;
  logic          id_chg, push, in_ready, fifo_ready, fifo_valid;

  assign id_chg = FlushOnIdChange && !pend_q && (cnt_q != '0) &&
                  (((IdWidth > 0) && (in_req_i.t.id != asm_q.id)) ||
                   ((DestWidth > 0) && (in_req_i.t.dest != asm_q.dest)));

  // A flushing beat or the first beat after a pending word always starts a fresh word.
  always_comb begin
    lane        = (pend_q || id_chg) ? '0 : cnt_q;
    beat_w      = '0;
    beat_w.data = DataWidthOut'(in_req_i.t.data) << (int'(lane) * DataWidthIn);
    beat_w.strb = SO'(in_req_i.t.strb) << (int'(lane) * SI);
    beat_w.keep = SO'(in_req_i.t.keep) << (int'(lane) * SI);
    beat_w.last = in_req_i.t.last;
    beat_w.id   = in_req_i.t.id;
    beat_w.dest = in_req_i.t.dest;
    beat_w.user = in_req_i.t.user;
    merged      = beat_w;
    merged.data = asm_q.data | beat_w.data;
    merged.strb = asm_q.strb | beat_w.strb;
    merged.keep = asm_q.keep | beat_w.keep;
  end

  // pend_q marks a one-beat word (id change plus last) that could not share the flush push.
  always_comb begin
    push      = 1'b0;
    push_word = asm_q;
    in_ready  = 1'b1;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    pend_d    = pend_q;
    if (pend_q) begin
      push     = 1'b1;
      in_ready = fifo_ready & ~in_req_i.t.last;
      if (fifo_ready) begin
        pend_d = 1'b0;
        asm_d  = '0;
        cnt_d  = '0;
        if (in_req_i.tvalid && in_ready) begin
          asm_d = beat_w;
          cnt_d = CW'(1);
        end
      end
    end else if (id_chg) begin
      push           = in_req_i.tvalid;
      push_word.last = 1'b0;
      in_ready       = fifo_ready;
      if (in_req_i.tvalid && fifo_ready) begin
        asm_d  = beat_w;
        cnt_d  = CW'(1);
        pend_d = in_req_i.t.last;
      end
    end else if (in_req_i.t.last || cnt_q == CW'(R - 1)) begin
      push      = in_req_i.tvalid;
      push_word = merged;
      in_ready  = fifo_ready;
      if (in_req_i.tvalid && fifo_ready) begin
        asm_d = '0;
        cnt_d = '0;
      end
    end else if (in_req_i.tvalid) begin
      asm_d = merged;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      asm_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      asm_q  <= asm_d;
      pend_q <= pend_d;
    end
  end

  stream_fifo #(
    .DEPTH (OutDepth),
    .T     (word_t)
  ) i_out_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .data_i  (push_word),
    .valid_i (push),
    .ready_o (fifo_ready),
    .data_o  (fifo_q),
    .valid_o (fifo_valid),
    .ready_i (out_rsp_i.tready)
  );

  always_comb begin
    in_rsp_o          = '0;
    in_rsp_o.tready   = in_ready;
    out_req_o         = '0;
    out_req_o.tvalid  = fifo_valid;
    out_req_o.t.data  = fifo_q.data;
    out_req_o.t.strb  = fifo_q.strb;
    out_req_o.t.keep  = fifo_q.keep;
    out_req_o.t.last  = fifo_q.last;
    out_req_o.t.id    = fifo_q.id;
    out_req_o.t.dest  = fifo_q.dest;
    out_req_o.t.user  = fifo_q.user;
  end

endmodule

// File: tb/tb_axi_stream_dw_upsizer_pipe.sv
// Bench for the 8 -> 32 bit upsizer: directed vector table, back-pressure and reset
// sequences, and randomized traffic checked against a beat-grouping scoreboard.
module tb_axi_stream_dw_upsizer_pipe;

  typedef struct packed {
    logic [7:0] data;
    logic [0:0] strb;
    logic [0:0] keep;
    logic       last;
    logic [1:0] id;
    logic [0:0] dest;
    logic [0:0] user;
  } in_t;
  typedef struct packed { logic tvalid; in_t t; } in_req_t;
  typedef struct packed { logic tready; } rsp_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  id;
    logic [0:0]  dest;
    logic [0:0]  user;
  } out_t;
  typedef struct packed { logic tvalid; out_t t; } out_req_t;
  typedef struct packed {
    logic        vld;
    logic [7:0]  data;
    logic [1:0]  id;
    logic        last;
    logic        exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic [1:0]  exp_id;
    logic        exp_last;
  } vec_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     done = 1'b0;
  in_req_t  in_req;
  rsp_t     in_rsp;
  out_req_t out_req;
  rsp_t     out_rsp;
  int       n_pass = 0, n_total = 0, n_pop = 0;
  in_t      cur[$];
  out_t     exp_q[$];

  always #5 clk = ~clk;

  axi_stream_dw_upsizer_pipe #(
    .DataWidthIn(8), .DataWidthOut(32), .IdWidth(2), .DestWidth(1), .UserWidth(1),
    .OutDepth(2), .FlushOnIdChange(1'b1),
    .axi_stream_in_req_t(in_req_t), .axi_stream_in_rsp_t(rsp_t),
    .axi_stream_out_req_t(out_req_t), .axi_stream_out_rsp_t(rsp_t)
  ) dut (
    .clk_i(clk), .rst_i(rst), .in_req_i(in_req), .in_rsp_o(in_rsp),
    .out_req_o(out_req), .out_rsp_i(out_rsp)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: beats collected in arrival order, lane i = i-th beat of the word.
  function automatic out_t pack_word(input in_t b[$]);
    out_t w = '0;
    foreach (b[i]) begin
      w.data[i*8 +: 8] = b[i].data;
      w.strb[i]        = b[i].strb[0];
      w.keep[i]        = b[i].keep[0];
    end
    w.last = b[$].last;
    w.id   = b[$].id;
    w.dest = b[$].dest;
    w.user = b[$].user;
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      cur.delete();
      exp_q.delete();
    end else begin
      if (in_req.tvalid && in_rsp.tready) begin
        if (cur.size() > 0 && (in_req.t.id != cur[$].id || in_req.t.dest != cur[$].dest)) begin
          exp_q.push_back(pack_word(cur));
          cur.delete();
        end
        cur.push_back(in_req.t);
        if (cur.size() == 4 || in_req.t.last) begin
          exp_q.push_back(pack_word(cur));
          cur.delete();
        end
      end
      if (out_req.tvalid && out_rsp.tready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_spurious: got word 0x%0h expected none", out_req.t);
        end else chk("sb_word", 64'(out_req.t), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input in_t beat, output int waits);
    waits         = 0;
    in_req.tvalid = 1'b1;
    in_req.t      = beat;
    @(negedge clk);
    while (!in_rsp.tready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_rsp.tready) begin
      n_total++;
      $display("FAIL send_timeout: tready 0 expected 1");
    end
    @(posedge clk); #1;
    in_req.tvalid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    in_t  b;
    int   waits, w, base;
    in_req = '0;
    out_rsp.tready = 1'b1;
    vt[0]  = '{1'b1, 8'h11, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0};
    vt[2]  = '{1'b1, 8'h33, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0};
    vt[3]  = '{1'b1, 8'h44, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0};
    vt[4]  = '{1'b1, 8'hAA, 2'd0, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF, 2'd0, 1'b1};
    vt[5]  = '{1'b1, 8'hBB, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0};
    vt[6]  = '{1'b1, 8'h01, 2'd1, 1'b0, 1'b1, 1'b1, 32'h0000BBAA, 4'h3, 2'd0, 1'b1};
    vt[7]  = '{1'b1, 8'h02, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0};
    vt[8]  = '{1'b1, 8'h03, 2'd2, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1, 32'h00000201, 4'h3, 2'd1, 1'b0};
    vt[10] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b1, 32'h00000003, 4'h1, 2'd2, 1'b1};
    vt[11] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_req.tvalid), 64'(0));
    chk("rst_out_t", 64'(out_req.t), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vector table, out tready held 1
    for (int i = 0; i < 12; i++) begin
      in_req        = '0;
      in_req.tvalid = vt[i].vld;
      in_req.t.data = vt[i].data;
      in_req.t.id   = vt[i].id;
      in_req.t.last = vt[i].last;
      in_req.t.strb = 1'b1;
      in_req.t.keep = 1'b1;
      @(negedge clk);
      if (vt[i].vld) chk($sformatf("tv%0d_in_ready", i), 64'(in_rsp.tready), 64'(vt[i].exp_rdy));
      chk($sformatf("tv%0d_out_valid", i), 64'(out_req.tvalid), 64'(vt[i].exp_ov));
      if (vt[i].exp_ov) begin
        chk($sformatf("tv%0d_data", i), 64'(out_req.t.data), 64'(vt[i].exp_data));
        chk($sformatf("tv%0d_keep", i), 64'(out_req.t.keep), 64'(vt[i].exp_keep));
        chk($sformatf("tv%0d_strb", i), 64'(out_req.t.strb), 64'(vt[i].exp_keep));
        chk($sformatf("tv%0d_id", i), 64'(out_req.t.id), 64'(vt[i].exp_id));
        chk($sformatf("tv%0d_last", i), 64'(out_req.t.last), 64'(vt[i].exp_last));
      end
      @(posedge clk); #1;
    end
    in_req = '0;

    // Continuous 16 beats: no input stalls, four words
    base = n_pop;
    w    = 0;
    for (int i = 0; i < 16; i++) begin
      b      = '0;
      b.data = 8'($urandom);
      b.strb = 1'b1;
      b.keep = 1'b1;
      b.last = (i == 15);
      send(b, waits);
      w += waits;
    end
    repeat (4) @(posedge clk); #1;
    chk("cont_stalls", 64'(w), 64'(0));
    chk("cont_words", 64'(n_pop - base), 64'(4));

    // Back-pressure: buffer fills, only the closing beat of word 3 stalls
    out_rsp.tready = 1'b0;
    base = n_pop;
    for (int i = 0; i < 11; i++) begin
      b      = '0;
      b.data = 8'(i + 1);
      b.strb = 1'b1;
      b.keep = 1'b1;
      b.last = ((i % 4) == 3);
      send(b, waits);
      chk($sformatf("bp_beat%0d_waits", i), 64'(waits), 64'(0));
    end
    b.data        = 8'd12;
    b.last        = 1'b1;
    in_req.tvalid = 1'b1;
    in_req.t      = b;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_close_ready", 64'(in_rsp.tready), 64'(0));
      chk("bp_hold_valid", 64'(out_req.tvalid), 64'(1));
      chk("bp_hold_data", 64'(out_req.t.data), 64'(32'h04030201));
    end
    @(posedge clk); #1;
    out_rsp.tready = 1'b1;
    send(b, waits);
    repeat (6) @(posedge clk); #1;
    chk("bp_words", 64'(n_pop - base), 64'(3));
    chk("bp_drained", 64'(exp_q.size()), 64'(0));

    // Randomized traffic with random output back-pressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          b      = '0;
          b.data = 8'($urandom);
          b.strb = 1'($urandom);
          b.keep = 1'b1;
          b.id   = 2'($urandom_range(0, 1));
          b.dest = 1'($urandom_range(0, 9) == 0);
          b.user = 1'($urandom);
          b.last = ($urandom_range(0, 5) == 0);
          send(b, waits);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_rsp.tready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_rsp.tready = 1'b1;
    repeat (10) @(posedge clk); #1;
    chk("rnd_drained", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of a packet
    b      = '0;
    b.strb = 1'b1;
    b.keep = 1'b1;
    b.data = 8'h5A;
    send(b, waits);
    b.data = 8'h6B;
    send(b, waits);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_req.tvalid), 64'(0));
    chk("mid_rst_out_t", 64'(out_req.t), 64'(0));
    @(posedge clk); #1;
    rst  = 1'b0;
    base = n_pop;
    for (int i = 0; i < 4; i++) begin
      b.data = 8'(8'hA1 + i);
      b.last = (i == 3);
      send(b, waits);
      chk($sformatf("post_rst_beat%0d_waits", i), 64'(waits), 64'(0));
    end
    @(negedge clk);
    chk("post_rst_valid", 64'(out_req.tvalid), 64'(1));
    chk("post_rst_data", 64'(out_req.t.data), 64'(32'hA4A3A2A1));
    chk("post_rst_keep", 64'(out_req.t.keep), 64'(4'hF));
    repeat (4) @(posedge clk); #1;
    chk("post_rst_words", 64'(n_pop - base), 64'(1));
    chk("post_rst_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
